uart_ram_loader: RTL

Parametrised UART-to-RAM bulk loader: assembles received UART bytes into DATA_W-bit words and writes WORD_COUNT consecutive words into a single-port block RAM starting at BASE_ADDR. It is the generalised successor of the byte-wide loader in the Picnic/SM4 data path and sits between the board UART pin and the key/plaintext/tape RAM. It adds word packing, byte-order selection, abort on start drop, a busy/word-count status and an optional inter-byte timeout.

---
 rtl/loader_pkg.sv | 19 +
 rtl/uart_rx.sv | 89 ++++++++
 rtl/uart_ram_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizing helpers for uart_ram_loader.
// ST_ERR exists only when LOADER_TIMEOUT_EN is defined.
package loader_pkg;

`ifdef LOADER_TIMEOUT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_DONE, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_DONE} state_t;
`endif

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int byte_idx_width(input int bytes_per_word_n);
        return (bytes_per_word_n > 1) ? $clog2(bytes_per_word_n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver. rx_done pulses for one cycle; rx_data holds the last
// byte until the next one completes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       rx_done,
    output logic [7:0] rx_data
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_done_q, rx_done_d;
    logic             rxd_s1_q, rxd_s2_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_done_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rxd_s2_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_BIT) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL_BIT) begin
                cnt_d   = '0;
                shift_d = {rxd_s2_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL_BIT) begin
                cnt_d   = '0;
                state_d = RX_IDLE;
                // A low stop bit is a framing error: the byte is dropped.
                if (rxd_s2_q) begin
                    rx_done_d = 1'b1;
                    rx_data_d = shift_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rx_done_q <= 1'b0;
            rxd_s1_q  <= 1'b1;
            rxd_s2_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_done_q <= rx_done_d;
            rxd_s1_q  <= uart_rxd;
            rxd_s2_q  <= rxd_s1_q;
        end
    end

    assign rx_done = rx_done_q;
    assign rx_data = rx_data_q;

endmodule

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: packs UART bytes into DATA_W-bit words and writes WORD_COUNT
// words to RAM from BASE_ADDR. Define LOADER_TIMEOUT_EN for the inter-byte timeout.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 15,
    parameter int WORD_COUNT   = 8864,
    parameter int BASE_ADDR    = 0,
    parameter int MSB_FIRST    = 1,
    parameter int TIMEOUT_CYC  = 1_000_000,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rxd,
    input  logic              start,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
    localparam int IDX_W          = byte_idx_width(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_COUNT - 1);

    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("uart_ram_loader: DATA_W must be a multiple of 8 in 8..64");
    end
    if (WORD_COUNT < 1 || TIMEOUT_CYC < 1 ||
        longint'(BASE_ADDR) + longint'(WORD_COUNT) - 1 >= (longint'(1) << ADDR_W)) begin : g_bad_range
        $error("uart_ram_loader: load window does not fit the address space");
    end

    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_d0_q, rx_d1_q;
    logic       byte_stb;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .uart_rxd (uart_rxd),
        .rx_done  (rx_done),
        .rx_data  (rx_data)
    );

    assign byte_stb = rx_d0_q & ~rx_d1_q;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     words_written_q, words_written_d;

    function automatic logic [DATA_W-1:0] place_byte(input logic [DATA_W-1:0] word,
                                                     input logic [IDX_W-1:0]  idx,
                                                     input logic [7:0]        b);
        logic [DATA_W-1:0] w;
        int                slot;
        w    = word;
        slot = (MSB_FIRST != 0) ? BYTES_PER_WORD - 1 - int'(idx) : int'(idx);
        for (int s = 0; s < BYTES_PER_WORD; s++) begin
            if (s == slot) w[s*8 +: 8] = b;
        end
        return w;
    endfunction

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             seen_q, seen_d;
    logic             err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        byte_idx_d      = byte_idx_q;
        word_idx_d      = word_idx_q;
        word_d          = word_q;
        ram_wdata_d     = ram_wdata_q;
        ram_addr_d      = ram_addr_q;
        ram_we_d        = 1'b0;
        busy_d          = busy_q;
        done_d          = done_q;
        words_written_d = words_written_q;
`ifdef LOADER_TIMEOUT_EN
        err_d           = err_q;
`endif
        case (state_q)
            ST_IDLE: if (start && !done_q && !err) begin
                state_d         = ST_COLLECT;
                byte_idx_d      = '0;
                word_idx_d      = '0;
                word_d          = '0;
                words_written_d = '0;
                busy_d          = 1'b1;
            end
            ST_COLLECT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (byte_stb) begin
                    word_d = place_byte(word_q, byte_idx_q, rx_data);
                    if (byte_idx_q == LAST_IDX) begin
                        state_d     = ST_WRITE;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = word_d;
                        ram_addr_d  = BASE + word_idx_q;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
`ifdef LOADER_TIMEOUT_EN
                else if (seen_q && tmo_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
`endif
            end
            ST_WRITE: begin
                // The write strobe is already out this cycle, so it counts even on abort.
                word_idx_d      = word_idx_q + 1'b1;
                words_written_d = words_written_q + 1'b1;
                byte_idx_d      = '0;
                if (!start) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (word_idx_q == LAST_WORD) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                    if (byte_stb) begin
                        word_d     = place_byte(word_q, '0, rx_data);
                        byte_idx_d = (BYTES_PER_WORD > 1) ? IDX_W'(1) : '0;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                word_idx_d = '0;
            end
`ifdef LOADER_TIMEOUT_EN
            ST_ERR: if (!start) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (!start) begin
            done_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
            err_d  = 1'b0;
`endif
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_comb begin
        tmo_d  = tmo_q;
        seen_d = seen_q;
        if (byte_stb || (state_d == ST_COLLECT && state_q != ST_COLLECT)) tmo_d = '0;
        else if (state_q == ST_COLLECT && seen_q) tmo_d = tmo_q + 1'b1;
        if (state_q == ST_IDLE) seen_d = 1'b0;
        else if (byte_stb && (state_q == ST_COLLECT || state_q == ST_WRITE)) seen_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q  <= '0;
            seen_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q         <= ST_IDLE;
            byte_idx_q      <= '0;
            word_idx_q      <= '0;
            word_q          <= '0;
            ram_wdata_q     <= '0;
            ram_addr_q      <= BASE;
            ram_we_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
            rx_d0_q         <= 1'b0;
            rx_d1_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_idx_q      <= byte_idx_d;
            word_idx_q      <= word_idx_d;
            word_q          <= word_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_addr_q      <= ram_addr_d;
            ram_we_q        <= ram_we_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            words_written_q <= words_written_d;
            rx_d0_q         <= rx_done;
            rx_d1_q         <= rx_d0_q;
        end
    end

    assign ram_wdata     = ram_wdata_q;
    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_written_q;

endmodule
